// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma rotor stepping logic.
// State codes are visible on the hex display through state_dbg.
package enigma_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_DEBOUNCE  = 4'd1,
    S_STEP      = 4'd2,
    S_SETTLE    = 4'd3,
    S_ENCRYPT   = 4'd4,
    S_RELEASE   = 4'd5,
    S_LOAD      = 4'd6,
    S_LOAD_HOLD = 4'd7
  } state_t;

  localparam int ROTOR_MAX   = 25;
  localparam int NOTCH_R_DEF = 16;
  localparam int NOTCH_M_DEF = 4;

  function automatic logic pos_ok(input logic [14:0] p);
    return (p[14:10] <= 5'(ROTOR_MAX)) &&
           (p[9:5]   <= 5'(ROTOR_MAX)) &&
           (p[4:0]   <= 5'(ROTOR_MAX));
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop key synchroniser plus a counter of consecutive cycles
// at the level the controller is currently waiting for.
module key_debouncer #(
  parameter int CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic active,
  input  logic want_pressed,
  output logic pressed,
  output logic done
);

  localparam int CW = $clog2(CYCLES + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          match;

  assign pressed = ~s2;
  assign match   = active & (pressed == want_pressed);
  assign done    = match & (cnt == CW'(CYCLES - 1));

  // A break in the level, an inactive phase or completion all restart at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= 1'b1;
      s2  <= 1'b1;
      cnt <= '0;
    end else begin
      s1  <= key_n;
      s2  <= s1;
      cnt <= (match && !done) ? cnt + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/rotor_step_controller.sv
// Turns debounced key presses into odometer rotor steps with the
// middle-rotor double-step, then strobes encryption; also gates loads.
module rotor_step_controller
  import enigma_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NOTCH_R         = NOTCH_R_DEF,
  parameter int NOTCH_M         = NOTCH_M_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_n,
  input  logic        load_req,
  input  logic [14:0] init_pos,
  input  logic [4:0]  pos_r,
  input  logic [4:0]  pos_m,
  input  logic [4:0]  pos_l,
  output logic        step_r,
  output logic        step_m,
  output logic        step_l,
  output logic        load_rotors,
  output logic        load_err,
  output logic        enc_strobe,
  output logic        busy,
  output logic [3:0]  state_dbg
);

  state_t state;
  state_t state_nx;
  logic   pressed;
  logic   done;
  logic   active;
  logic   want_pressed;
  logic   in_step;
  logic   notch_m_hit;
  logic   unused_pos_l;

  assign active       = (state == S_DEBOUNCE) || (state == S_RELEASE);
  assign want_pressed = (state == S_DEBOUNCE);
  assign unused_pos_l = ^pos_l;

  key_debouncer #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk         (clk),
    .reset       (reset),
    .key_n       (key_n),
    .active      (active),
    .want_pressed(want_pressed),
    .pressed     (pressed),
    .done        (done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_RELEASE;
      load_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_LOAD)
        load_err <= ~pos_ok(init_pos);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (load_req)
          state_nx = S_LOAD;
        else if (pressed)
          state_nx = S_DEBOUNCE;
      end
      S_DEBOUNCE: begin
        if (!pressed)
          state_nx = S_IDLE;
        else if (done)
          state_nx = S_STEP;
      end
      S_STEP:    state_nx = S_SETTLE;
      S_SETTLE:  state_nx = S_ENCRYPT;
      S_ENCRYPT: state_nx = S_RELEASE;
      S_RELEASE: begin
        if (done)
          state_nx = S_IDLE;
      end
      S_LOAD:    state_nx = S_LOAD_HOLD;
      S_LOAD_HOLD: begin
        if (!load_req)
          state_nx = S_IDLE;
      end
      default:   state_nx = S_RELEASE;
    endcase
  end

  // Notches are judged on the positions present during the STEP cycle.
  assign in_step     = (state == S_STEP);
  assign notch_m_hit = (pos_m == 5'(NOTCH_M));
  assign step_r      = in_step;
  assign step_m      = in_step & ((pos_r == 5'(NOTCH_R)) | notch_m_hit);
  assign step_l      = in_step & notch_m_hit;
  assign load_rotors = (state == S_LOAD) & pos_ok(init_pos);
  assign enc_strobe  = (state == S_ENCRYPT);
  assign busy        = (state != S_IDLE);
  assign state_dbg   = state;

endmodule
